id_pulse_scheduler: RTL and testbench
=====================================

ID_PULSE_SCHEDULER -- requirements
Module: id_pulse_scheduler

Interface
REQ-001 The block SHALL have parameter GUARD_CYCLES, default 4, giving the minimum spacing in clk cycles between issued correction pulses (legal 2..255).
REQ-002 The block SHALL have parameter PEND_W, default 4, giving the width of the signed pending-correction accumulator.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port incReq  input  1  one-cycle advance request from the loop filter (carry).
REQ-006 The block SHALL have port decReq  input  1  one-cycle retard request from the loop filter (borrow).
REQ-007 The block SHALL have port enable  input  1  high permits new pulses to be issued.
REQ-008 The block SHALL have port flush  input  1  high clears all pending corrections.
REQ-009 The block SHALL have port incOut  output  1  registered one-cycle increment pulse to the increment/decrement counter.
REQ-010 The block SHALL have port decOut  output  1  registered one-cycle decrement pulse to the increment/decrement counter.
REQ-011 The block SHALL have port busy  output  1  high while state is ISSUE or GUARD.
REQ-012 The block SHALL have port pending  output  PEND_W  signed net count of unissued corrections.
REQ-013 The block SHALL have port satFlag  output  1  sticky flag: a request was lost to accumulator saturation.
REQ-014 The block SHALL have port dropCount  output  8  saturating count of lost requests.

Function
REQ-015 The accumulator SHALL range -(2^(PEND_W-1)-1)..+(2^(PEND_W-1)-1), i.e. -7..+7 at default.
REQ-016 Each cycle the accumulator SHALL update by (+1 if incReq) + (-1 if decReq) + (issue correction: -1 on an incOut cycle, +1 on a decOut cycle).
REQ-017 incReq and decReq high in the same cycle SHALL cancel: net zero, no drop counted.
REQ-018 A request that would push the accumulator beyond a limit SHALL leave it at the limit, set satFlag and increment dropCount (holding at 255).
REQ-019 The FSM SHALL have states IDLE, ISSUE, GUARD.
REQ-020 IDLE -> ISSUE when enable=1 and registered pending != 0; otherwise stay IDLE.
REQ-021 In ISSUE, exactly one of incOut (pending>0) or decOut (pending<0) SHALL be high, for exactly that one cycle; next state GUARD.
REQ-022 GUARD SHALL last GUARD_CYCLES-1 cycles via a down-counter, then return to IDLE, so consecutive pulses are exactly GUARD_CYCLES cycles apart when work is continuous.
REQ-023 Latency: request in cycle t with IDLE and pending previously 0 SHALL produce the output pulse in cycle t+2.
REQ-024 Direction SHALL be chosen from the registered pending value at the ISSUE decision; sign reversal between pulses is permitted.
REQ-025 enable deasserted during ISSUE or GUARD SHALL NOT abort the sequence; the FSM completes to IDLE and then waits.
REQ-026 Requests SHALL keep accumulating while enable=0.
REQ-027 flush=1 SHALL set pending to 0 next edge, discarding same-cycle requests; an in-flight ISSUE still outputs its pulse and GUARD completes; satFlag SHALL clear, dropCount SHALL NOT clear.
REQ-028 incOut and decOut SHALL never be high in the same cycle.

Reset
REQ-029 reset=1 at a rising edge SHALL force state IDLE, guard counter 0, pending 0, incOut 0, decOut 0, busy 0, satFlag 0, dropCount 0, overriding all other inputs including an ISSUE in progress.
REQ-030 Reset asserted mid-GUARD SHALL produce no further pulse for previously pending corrections.

Verification
REQ-031 Single incReq at cycle 10, enable=1 -> incOut high in cycle 12 only; pending returns to 0; busy high cycles 12-15.
REQ-032 Three incReq pulses in cycles 10-12 -> incOut in cycles 12, 16, 20; pending sequence 1,2,2,1,... ends 0.
REQ-033 incReq and decReq together for 20 cycles -> no pulses, pending 0, dropCount 0.
REQ-034 Ten decReq with enable=0, then enable=1 -> pending saturates at -7, satFlag=1, dropCount=3, then seven decOut pulses 4 cycles apart.
REQ-035 Pending=+5, flush pulsed during GUARD -> no further incOut, pending 0, satFlag 0.
REQ-036 reset pulsed in an ISSUE cycle with pending=+3 -> all outputs 0 next cycle, no pulses afterwards.

Source files
------------

// File: rtl/id_pulse_scheduler.sv
// id_pulse_scheduler: accumulates advance/retard requests from a loop filter
// into a signed pending count and meters them out as single-cycle
// increment/decrement pulses spaced at least GUARD_CYCLES apart.
//
// Handshake: there is no back-pressure. incReq/decReq are one-cycle strobes
// sampled on every rising edge; incOut/decOut are registered one-cycle
// strobes that the downstream counter must accept on the cycle they are high.
module id_pulse_scheduler #(
    parameter int GUARD_CYCLES = 4,
    parameter int PEND_W       = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     incReq,
    input  logic                     decReq,
    input  logic                     enable,
    input  logic                     flush,
    output logic                     incOut,
    output logic                     decOut,
    output logic                     busy,
    output logic signed [PEND_W-1:0] pending,
    output logic                     satFlag,
    output logic [7:0]               dropCount,
    output logic [1:0]               dbgState
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GUARD = 2'd2
    } state_e;

    // Two guard bits so the sum of three +/-1 terms never wraps before clamping.
    localparam int SW = PEND_W + 2;
    localparam logic signed [SW-1:0] ONE_W  = SW'(1);
    localparam logic signed [SW-1:0] PMAX_W = SW'((1 << (PEND_W - 1)) - 1);
    localparam logic signed [SW-1:0] NMAX_W = -PMAX_W;
    localparam logic [7:0]           GUARD_LOAD = 8'(GUARD_CYCLES - 1);

    state_e                   state_q, state_d;
    logic [7:0]               guard_q, guard_d;
    logic signed [PEND_W-1:0] pending_q, pending_d;
    logic                     inc_q, inc_d;
    logic                     dec_q, dec_d;
    logic                     sat_q, sat_d;
    logic [7:0]               drop_q, drop_d;
    logic signed [SW-1:0]     sum_w;
    logic                     lost;
    logic                     go;

    // Accumulator: requests plus the correction just issued, clamped to +/-PMAX.
    always_comb begin
        sum_w = {{2{pending_q[PEND_W-1]}}, pending_q};
        if (incReq && !decReq) sum_w = sum_w + ONE_W;
        if (decReq && !incReq) sum_w = sum_w - ONE_W;
        if (inc_q)             sum_w = sum_w - ONE_W;
        if (dec_q)             sum_w = sum_w + ONE_W;
        lost      = 1'b0;
        pending_d = sum_w[PEND_W-1:0];
        if (sum_w > PMAX_W) begin
            pending_d = PMAX_W[PEND_W-1:0];
            lost      = 1'b1;
        end else if (sum_w < NMAX_W) begin
            pending_d = NMAX_W[PEND_W-1:0];
            lost      = 1'b1;
        end
        sat_d  = sat_q | lost;
        drop_d = (lost && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
        // Flush discards everything pending, including this cycle's requests,
        // so nothing is lost to saturation and the drop history is kept.
        if (flush) begin
            pending_d = '0;
            sat_d     = 1'b0;
            drop_d    = drop_q;
        end
    end

    // A pulse may start only from registered work that is not being flushed.
    assign go = enable && (pending_q != '0) && !flush;

    // Next-state logic; the last GUARD cycle decides like IDLE so that
    // back-to-back pulses are exactly GUARD_CYCLES apart.
    always_comb begin
        state_d = state_q;
        guard_d = guard_q;
        case (state_q)
            IDLE: begin
                if (go) state_d = ISSUE;
            end
            ISSUE: begin
                state_d = GUARD;
                guard_d = GUARD_LOAD;
            end
            GUARD: begin
                if (guard_q <= 8'd1) begin
                    guard_d = 8'd0;
                    state_d = go ? ISSUE : IDLE;
                end else begin
                    guard_d = guard_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                guard_d = 8'd0;
            end
        endcase
        inc_d = 1'b0;
        dec_d = 1'b0;
        if (state_d == ISSUE) begin
            inc_d = !pending_q[PEND_W-1];
            dec_d =  pending_q[PEND_W-1];
        end
    end

    // State, counters and registered outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            guard_q   <= 8'd0;
            pending_q <= '0;
            inc_q     <= 1'b0;
            dec_q     <= 1'b0;
            sat_q     <= 1'b0;
            drop_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            guard_q   <= guard_d;
            pending_q <= pending_d;
            inc_q     <= inc_d;
            dec_q     <= dec_d;
            sat_q     <= sat_d;
            drop_q    <= drop_d;
        end
    end

    assign incOut    = inc_q;
    assign decOut    = dec_q;
    assign busy      = (state_q == ISSUE) || (state_q == GUARD);
    assign pending   = pending_q;
    assign satFlag   = sat_q;
    assign dropCount = drop_q;
    assign dbgState  = state_q;

endmodule

// File: tb/tb_id_pulse_scheduler.sv
// Bench for id_pulse_scheduler: directed request sequences; each expected
// pulse (cycle and direction) goes into exp_q, and a monitor pops and
// compares whenever incOut or decOut is seen.
module tb_id_pulse_scheduler;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              incReq = 1'b0;
    logic              decReq = 1'b0;
    logic              enable = 1'b0;
    logic              flush = 1'b0;
    logic              incOut;
    logic              decOut;
    logic              busy;
    logic signed [3:0] pending;
    logic              satFlag;
    logic [7:0]        dropCount;
    logic [1:0]        dbgState;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;

    // Expected pulse entry: bit 31 = 1 for decOut, low bits = cycle number.
    logic [31:0] exp_q[$];

    id_pulse_scheduler #(.GUARD_CYCLES(4), .PEND_W(4)) dut (
        .clk(clk), .reset(reset), .incReq(incReq), .decReq(decReq),
        .enable(enable), .flush(flush), .incOut(incOut), .decOut(decOut),
        .busy(busy), .pending(pending), .satFlag(satFlag),
        .dropCount(dropCount), .dbgState(dbgState)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- driver tasks ----------------
    // Drive one cycle of requests; returns #1 after the sampling edge.
    task automatic step(input logic inc, input logic dec);
        incReq = inc;
        decReq = dec;
        @(posedge clk);
        #1;
        incReq = 1'b0;
        decReq = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic expect_pulse(input int at_cycle, input logic is_dec);
        exp_q.push_back({is_dec, 31'(at_cycle)});
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [31:0] e;
        if (incOut && decOut) check("both_pulses", 1, 0);
        if (incOut || decOut) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", cyc, -1);
            end else begin
                e = exp_q.pop_front();
                check("pulse_cycle", cyc, int'(e[30:0]));
                check("pulse_dir_dec", int'(decOut), int'(e[31]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int t;
        int e;
        #1;
        idle(3);
        reset = 1'b0;
        check("rst_pending", pending, 0);
        check("rst_busy", busy, 0);
        check("rst_inc", incOut, 0);
        check("rst_dec", decOut, 0);
        check("rst_sat", satFlag, 0);
        check("rst_drop", dropCount, 0);
        enable = 1'b1;
        idle(2);

        // Single request: pulse two cycles later, busy for four cycles.
        t = cyc;
        expect_pulse(t + 2, 1'b0);
        step(1'b1, 1'b0);
        check("t1_pend_after_req", pending, 1);
        check("t1_busy_before", busy, 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0);
            check("t1_busy_window", busy, 1);
        end
        step(1'b0, 1'b0);
        check("t1_busy_done", busy, 0);
        check("t1_pend_done", pending, 0);
        idle(3);

        // Three back-to-back requests: pulses at +2, +6, +10.
        t = cyc;
        expect_pulse(t + 2, 1'b0);
        expect_pulse(t + 6, 1'b0);
        expect_pulse(t + 10, 1'b0);
        step(1'b1, 1'b0);
        check("t2_pend1", pending, 1);
        step(1'b1, 1'b0);
        check("t2_pend2", pending, 2);
        step(1'b1, 1'b0);
        check("t2_pend3", pending, 2);
        idle(4);
        check("t2_pend_after_second", pending, 1);
        idle(8);
        check("t2_pend_end", pending, 0);

        // Simultaneous inc and dec cancel.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
        check("t3_pend", pending, 0);
        check("t3_drop", dropCount, 0);
        check("t3_busy", busy, 0);

        // Saturation while disabled, then drain with seven decOut pulses.
        enable = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
        check("t4_pend_sat", pending, -7);
        check("t4_sat", satFlag, 1);
        check("t4_drop", dropCount, 3);
        check("t4_busy_disabled", busy, 0);
        enable = 1'b1;
        e = cyc;
        for (int k = 0; k < 7; k++) expect_pulse(e + 1 + 4 * k, 1'b1);
        idle(35);
        check("t4_pend_end", pending, 0);
        check("t4_sat_sticky", satFlag, 1);

        // Flush during GUARD stops further pulses and clears satFlag.
        enable = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        check("t5_pend5", pending, 5);
        enable = 1'b1;
        e = cyc;
        expect_pulse(e + 1, 1'b0);
        idle(2);
        check("t5_in_guard", int'(dbgState), 2);
        flush = 1'b1;
        step(1'b1, 1'b0);
        flush = 1'b0;
        check("t5_pend_flushed", pending, 0);
        idle(20);
        check("t5_pend_end", pending, 0);
        check("t5_sat_cleared", satFlag, 0);
        check("t5_drop_kept", dropCount, 3);

        // Reset during an ISSUE cycle with pending +3.
        enable = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        enable = 1'b1;
        e = cyc;
        expect_pulse(e + 1, 1'b0);
        step(1'b0, 1'b0);
        check("t6_issue_now", int'(dbgState), 1);
        reset = 1'b1;
        step(1'b0, 1'b0);
        reset = 1'b0;
        check("t6_inc", incOut, 0);
        check("t6_dec", decOut, 0);
        check("t6_busy", busy, 0);
        check("t6_pend", pending, 0);
        check("t6_drop", dropCount, 0);
        idle(20);
        check("t6_busy_after", busy, 0);

        check("exp_q_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
